// File: rtl/avalon_st_pkg.sv
// Shared constants and types for the Avalon-ST narrow-to-wide packer.
package avalon_st_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef logic [31:0] word_count_t;

  function automatic int unsigned lane_width(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/avalon_st_packer.sv
// Packs RATIO narrow Avalon-ST beats into one registered wide beat; sink_eop
// flushes a partial word early with an empty-lane count.
module avalon_st_packer
  import avalon_st_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned RATIO      = 4,
  localparam int unsigned LANE_W    = lane_width(RATIO)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sink_valid,
  output logic                        sink_ready,
  input  logic [DATA_WIDTH-1:0]       sink_data,
  input  logic                        sink_eop,
  output logic                        src_valid,
  input  logic                        src_ready,
  output logic [DATA_WIDTH*RATIO-1:0] src_data,
  output logic                        src_eop,
  output logic [LANE_W-1:0]           src_empty,
  output logic [31:0]                 word_count
);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_ratio_check
    $error("avalon_st_packer: RATIO must be a power of two and >= 2");
  end

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [DATA_WIDTH*RATIO-1:0] acc;
  logic [DATA_WIDTH*RATIO-1:0] merged;
  logic [LANE_W-1:0]           lane;
  logic                        sink_fire;
  logic                        src_fire;
  logic                        completing;
  word_count_t                 word_count_next;

  assign sink_ready      = !reset && (!src_valid || src_ready);
  assign sink_fire       = sink_valid && sink_ready;
  assign src_fire        = src_valid && src_ready;
  assign completing      = sink_eop || (lane == LAST_LANE);
  assign word_count_next = word_count + 32'd1;

  // Lanes above the current one are always zero in acc (cleared at every
  // word boundary), so inserting the new beat yields the zero-padded word.
  always_comb begin
    merged = acc;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (lane == LANE_W'(k)) begin
        merged[k*DATA_WIDTH +: DATA_WIDTH] = sink_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      lane       <= '0;
      src_valid  <= 1'b0;
      src_data   <= '0;
      src_eop    <= 1'b0;
      src_empty  <= '0;
      word_count <= '0;
    end else begin
      if (src_fire) begin
        src_valid  <= 1'b0;
        word_count <= word_count_next;
      end
      if (sink_fire) begin
        if (completing) begin
          src_data  <= merged;
          src_eop   <= sink_eop;
          src_empty <= LAST_LANE - lane;
          src_valid <= 1'b1;
          acc       <= '0;
          lane      <= '0;
        end else begin
          acc  <= merged;
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_st_packer.sv
// Randomised scoreboard bench for avalon_st_packer with directed scenarios.
module tb_avalon_st_packer;

  localparam int DW = 32;
  localparam int R  = 4;
  localparam int LW = 2;
  localparam int WW = DW * R;

  logic          clk = 1'b0;
  logic          reset;
  logic          sink_valid;
  logic          sink_ready;
  logic [DW-1:0] sink_data;
  logic          sink_eop;
  logic          src_valid;
  logic          src_ready = 1'b1;
  logic [WW-1:0] src_data;
  logic          src_eop;
  logic [LW-1:0] src_empty;
  logic [31:0]   word_count;

  avalon_st_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .sink_data  (sink_data),
    .sink_eop   (sink_eop),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .src_eop    (src_eop),
    .src_empty  (src_empty),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] data;
    logic          eop;
    int            empty;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] part_q[$];
  word_t         w_pop;
  word_t         w_new;

  int checks  = 0;
  int errors  = 0;
  int n_acc   = 0;
  int n_xfer  = 0;
  int stalls  = 0;
  int rdy_mode = 0;

  logic [WW-1:0] last_data = '0;
  logic          last_eop = 1'b0;
  logic [LW-1:0] last_empty = '0;
  logic          prev_stall = 1'b0;
  logic          prev_complete = 1'b0;
  logic [WW-1:0] hold_data;
  logic          hold_eop;
  logic [LW-1:0] hold_empty;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // src_ready pattern generator
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = 1'b0;
        default: src_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: reference model on accepted sink beats, scoreboard on wide beats
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        part_q.delete();
        n_xfer = 0;
        prev_stall = 1'b0;
        prev_complete = 1'b0;
      end else begin
        chk("sink_ready", WW'(sink_ready), WW'(!src_valid || src_ready));
        if (prev_complete) chk("latency_valid", WW'(src_valid), WW'(1));
        if (prev_stall) begin
          chk("hold_valid", WW'(src_valid), WW'(1));
          chk("hold_data", src_data, hold_data);
          chk("hold_eop", WW'(src_eop), WW'(hold_eop));
          chk("hold_empty", WW'(src_empty), WW'(hold_empty));
        end
        if (src_valid && src_ready) begin
          chk("word_count", WW'(word_count), WW'(n_xfer));
          n_xfer++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", src_data);
          end else begin
            w_pop = exp_q.pop_front();
            chk("src_data", src_data, w_pop.data);
            chk("src_eop", WW'(src_eop), WW'(w_pop.eop));
            chk("src_empty", WW'(src_empty), WW'(w_pop.empty));
          end
          last_data  = src_data;
          last_eop   = src_eop;
          last_empty = src_empty;
        end
        prev_stall = src_valid && !src_ready;
        hold_data  = src_data;
        hold_eop   = src_eop;
        hold_empty = src_empty;
        prev_complete = 1'b0;
        if (sink_valid && sink_ready) begin
          n_acc++;
          part_q.push_back(sink_data);
          if (sink_eop || part_q.size() == R) begin
            w_new.data = '0;
            foreach (part_q[i]) w_new.data[i*DW +: DW] = part_q[i];
            w_new.eop   = sink_eop;
            w_new.empty = R - part_q.size();
            exp_q.push_back(w_new);
            part_q.delete();
            prev_complete = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic e);
    bit ok = 1'b0;
    sink_valid = 1'b1;
    sink_data  = d;
    sink_eop   = e;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sink_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got sink_ready=0 for 2000 cycles expected acceptance");
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    sink_valid = 1'b0;
    sink_eop   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] wc0;
  int          s0;
  int          a0;
  int          a_base;
  logic [DW-1:0] rb[4];

  initial begin
    reset = 1'b1;
    sink_valid = 1'b0;
    sink_data = '0;
    sink_eop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sink_ready", WW'(sink_ready), WW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_src_valid", WW'(src_valid), WW'(0));
    chk("reset_src_data", src_data, '0);
    chk("reset_src_eop", WW'(src_eop), WW'(0));
    chk("reset_src_empty", WW'(src_empty), WW'(0));
    chk("reset_word_count", WW'(word_count), WW'(0));
    @(posedge clk);
    #1;

    // full word
    send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b0);
    idle(3);
    chk("t1_data", last_data, 128'h00000044_00000033_00000022_00000011);
    chk("t1_empty", WW'(last_empty), WW'(0));
    chk("t1_eop", WW'(last_eop), WW'(0));
    chk("t1_word_count", WW'(word_count), WW'(1));

    // partial word closed by eop on lane 1
    send(32'hA, 1'b0); send(32'hB, 1'b1);
    idle(3);
    chk("t2_data", last_data, 128'h0000000B_0000000A);
    chk("t2_empty", WW'(last_empty), WW'(2));
    chk("t2_eop", WW'(last_eop), WW'(1));

    // eop on lane 0
    send(32'h5, 1'b1);
    idle(3);
    chk("t3_data", last_data, 128'h5);
    chk("t3_empty", WW'(last_empty), WW'(3));

    // backpressure
    rdy_mode = 1;
    idle(2);
    a_base = n_acc;
    fork
      begin
        for (int k = 0; k < 8; k++) send(32'h100 + k, 1'b0);
      end
      begin
        for (int c = 0; c < 50 && !src_valid; c++) @(negedge clk);
        chk("bp_valid_rise", WW'(src_valid), WW'(1));
        a0 = n_acc;
        repeat (5) begin
          @(negedge clk);
          chk("bp_sink_ready", WW'(sink_ready), WW'(0));
        end
        chk("bp_no_accept", WW'(n_acc - a0), WW'(0));
        chk("bp_accepted", WW'(n_acc - a_base), WW'(4));
        rdy_mode = 0;
      end
    join
    idle(4);
    chk("bp_words", WW'(word_count), WW'(5));

    // sustained stream
    wc0 = word_count;
    s0 = stalls;
    for (int k = 0; k < 400; k++) send($urandom, 1'b0);
    idle(4);
    chk("stream_words", WW'(word_count - wc0), WW'(100));
    chk("stream_stalls", WW'(stalls - s0), WW'(0));

    // reset mid-word
    send(32'hDEAD0001, 1'b0); send(32'hDEAD0002, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", WW'(src_valid), WW'(0));
    chk("rst_mid_count", WW'(word_count), WW'(0));
    @(posedge clk);
    #1;
    foreach (rb[i]) rb[i] = $urandom;
    foreach (rb[i]) send(rb[i], 1'b0);
    idle(3);
    chk("rst_clean_data", last_data, {rb[3], rb[2], rb[1], rb[0]});
    chk("rst_clean_count", WW'(word_count), WW'(1));

    // random traffic with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send($urandom, $urandom_range(0, 5) == 0);
    end
    send($urandom, 1'b1);
    rdy_mode = 0;
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !src_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", WW'(exp_q.size()), WW'(0));
    chk("drain_valid", WW'(src_valid), WW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_st_packer.md
Name: avalon_st_packer

Overview:
- Downstream stage of the Avalon-ST FIFO. It consumes the FIFO's narrow source stream and packs RATIO consecutive DATA_WIDTH beats into one wide beat.
- A sink-side end-of-packet marker forces early emission of a partial wide beat, with an empty-lane count.
- Feeds the wide datapath (DMA/bus bridge) with registered outputs and valid/ready backpressure.

Parameters:
- DATA_WIDTH, 32: narrow beat width, bits.
- RATIO, 4: narrow beats per wide beat; power of two, >= 2.
- LANE_W, $clog2(RATIO): derived, not overridable; width of lane index and src_empty.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sink_valid  in  1  narrow beat valid (from FIFO source valid).
- sink_ready  out  1  packer can accept a narrow beat.
- sink_data  in  DATA_WIDTH  narrow beat payload.
- sink_eop  in  1  beat is last of packet.
- src_valid  out  1  wide beat valid.
- src_ready  in  1  downstream accepts wide beat.
- src_data  out  DATA_WIDTH*RATIO  wide beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- src_eop  out  1  wide beat closes a packet.
- src_empty  out  LANE_W  count of unused (zeroed) upper lanes; valid with src_valid.
- word_count  out  32  wide beats delivered (src_valid & src_ready), wraps at 2^32.

Behaviour:
- Transfers: a sink transfer is sink_valid & sink_ready. A source transfer is src_valid & src_ready.
- Reset (sync, any cycle, mid-packet included):
  - src_valid=0, src_data=0, src_eop=0, src_empty=0, word_count=0.
  - lane=0, accumulator cleared.
  - Any partial word is discarded.
  - sink_ready=0 while reset is high.
- sink_ready = !reset & (!src_valid | src_ready). It is independent of sink_valid, sink_data and sink_eop.
- Lane counter and placement:
  - lane (LANE_W bits) selects the accumulator lane for the next sink transfer.
  - The first beat of a word lands in lane 0 (LSBs).
- Non-completing beat (lane != RATIO-1 and sink_eop=0): write sink_data into accumulator lane, lane <= lane+1. No source change.
- Completing beat (lane == RATIO-1, or sink_eop=1):
  - src_data <= accumulator lanes below lane, plus sink_data in lane, plus zeros above lane.
  - src_eop <= sink_eop.
  - src_empty <= RATIO-1-lane.
  - src_valid <= 1.
  - Accumulator cleared, lane <= 0.
- Latency: completing beat accepted in cycle N gives src_valid=1 in cycle N+1.
- Throughput: one narrow beat per cycle sustained while src_ready=1 whenever src_valid=1.
- Source hold: src_valid stays 1 and src_data/src_eop/src_empty stay stable until a source transfer.
  - On a source transfer with no completing beat in the same cycle, src_valid <= 0.
- Simultaneous events: source transfer and completing sink beat in the same cycle load the new wide beat with src_valid staying 1; no bubble.
- Backpressure:
  - With src_valid=1 and src_ready=0, sink_ready=0 and no beats are accepted, including non-completing ones.
  - The accumulator is unchanged.
- eop on lane 0: emits a wide beat with src_empty=RATIO-1 and only lane 0 populated.
- eop on lane RATIO-1: src_empty=0, src_eop=1.
- Lane wrap: after lane RATIO-1 the counter returns to 0, with no overflow state.
- word_count increments on every source transfer and wraps modulo 2^32.
- No partial word is ever emitted without sink_eop. An idle sink holds the partial accumulator indefinitely.
- Elaboration: an error is raised if RATIO is not a power of two or RATIO < 2.

Decomposition:
- Package avalon_st_pkg:
  - default DATA_WIDTH constant.
  - function lane_width(ratio) returning $clog2.
  - typedef for word_count (logic [31:0]).
- Sub-module: none required. The accumulator, lane counter and output register fit cleanly in one module.
- The sink side is wired directly to the FIFO's AvalonStream source signals at the integration level.

Test Plan:
- Reset, then beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles with src_ready=1 -> one cycle after the 4th beat: src_data=0x00000044_00000033_00000022_00000011, src_empty=0, src_eop=0, word_count=1 after the transfer.
- Beats 0xA, 0xB with eop on 0xB -> src_data=0x0..0_0000000B_0000000A, src_empty=2, src_eop=1; the next beat lands in lane 0.
- Single beat 0x5 with eop -> src_empty=3, lane 0=0x5, lanes 1-3=0.
- 8 beats back-to-back with src_ready held 0 after the first wide beat -> sink_ready drops the cycle src_valid rises. The held wide beat stays stable 5 cycles. Raising src_ready drains it and sink_ready rises in the same cycle. The second word arrives intact with no lost or duplicated beats.
- Continuous stream of 400 beats, src_ready=1 -> 100 wide beats, no bubbles between completing beat and output, word_count=100.
- Reset asserted after 2 beats of a word -> src_valid=0, lane=0. The next 4 beats form a clean word with no stale data from the discarded partial.
